ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 11 +
 rtl/rr_arbiter2.sv | 19 +
 rtl/ram_arbiter.sv | 122 ++++++++++++
 tb/tb_ram_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared constants and FSM encoding for the RAM arbiter
package ram_arbiter_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    ST_SERVE = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant, pointer names the favoured requester on contention
module rr_arbiter2
  import ram_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_ptr,
  output logic [NUM_REQ-1:0] o_grant
);

  always_comb begin
    o_grant = '0;
    if (i_req[0] && i_req[1]) begin
      o_grant[i_ptr] = 1'b1;
    end else begin
      o_grant = i_req;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester round-robin front end for a single-port RAM with a full-clear engine
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ-1:0]              req_write_i,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]           rsp_data_o,
  input  logic                            clear_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [ADDRESS_WIDTH-1:0]        ram_address_o,
  output logic [DATA_WIDTH-1:0]           ram_data_o,
  output logic                            ram_write_en_o,
  input  logic [DATA_WIDTH-1:0]           ram_data_i
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;

  state_e              r_state;
  state_e              w_state_next;
  logic [AW-1:0]       r_count;
  logic [AW-1:0]       r_last_addr;
  logic                r_ptr;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DW-1:0]       r_rsp_data;
  logic                r_done;

  logic [NUM_REQ-1:0]  w_req;
  logic [NUM_REQ-1:0]  w_grant;
  logic [NUM_REQ-1:0]  w_read_grant;
  logic                w_sel;
  logic                w_clear_last;

  // A clear request steals the cycle, so nobody is granted while it is seen.
  assign w_req        = (rst_n && r_state == ST_SERVE && !clear_i) ? req_valid_i : '0;
  assign w_sel        = w_grant[1];
  assign w_read_grant = w_grant & ~req_write_i;
  assign w_clear_last = (r_state == ST_CLEAR) && (r_count == '1);

  rr_arbiter2 u_rr_arbiter2 (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SERVE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_SERVE: if (clear_i) w_state_next = ST_CLEAR;
      ST_CLEAR: if (w_clear_last) w_state_next = ST_SERVE;
      default:  w_state_next = ST_SERVE;
    endcase
  end

  always_comb begin
    req_ready_o    = w_grant;
    busy_o         = (r_state == ST_CLEAR);
    ram_write_en_o = 1'b0;
    ram_address_o  = r_last_addr;
    ram_data_o     = '0;
    if (r_state == ST_CLEAR) begin
      ram_write_en_o = 1'b1;
      ram_address_o  = r_count;
    end else if (|w_grant) begin
      ram_write_en_o = req_write_i[w_sel];
      ram_address_o  = w_sel ? req_address_i[AW +: AW] : req_address_i[0 +: AW];
      ram_data_o     = w_sel ? req_data_i[DW +: DW] : req_data_i[0 +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_last_addr <= '0;
      r_ptr       <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= w_clear_last;
      r_rsp_valid <= w_read_grant;
      if (|w_read_grant) begin
        r_rsp_data <= ram_data_i;
      end
      if (|w_grant) begin
        r_ptr <= ~w_sel;
      end
      if ((|w_grant) || r_state == ST_CLEAR) begin
        r_last_addr <= ram_address_o;
      end
      // Counter parks on the last address once the sweep ends; it is reloaded on the next clear.
      if (r_state == ST_SERVE && clear_i) begin
        r_count <= '0;
      end else if (r_state == ST_CLEAR && !w_clear_last) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign done_o      = r_done;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - randomized and directed checks of ram_arbiter against a behavioural model
module tb_ram_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int MS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      req_valid_i = '0;
  logic [1:0]      req_write_i = '0;
  logic [2*AW-1:0] req_address_i = '0;
  logic [2*DW-1:0] req_data_i = '0;
  logic            clear_i = 1'b0;
  logic [1:0]      req_ready_o;
  logic [1:0]      rsp_valid_o;
  logic [DW-1:0]   rsp_data_o;
  logic            busy_o;
  logic            done_o;
  logic [AW-1:0]   ram_address_o;
  logic [DW-1:0]   ram_data_o;
  logic            ram_write_en_o;
  logic [DW-1:0]   ram_data_i;

  ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_write_i    (req_write_i),
    .req_address_i  (req_address_i),
    .req_data_i     (req_data_i),
    .req_ready_o    (req_ready_o),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_data_o     (rsp_data_o),
    .clear_i        (clear_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .ram_address_o  (ram_address_o),
    .ram_data_o     (ram_data_o),
    .ram_write_en_o (ram_write_en_o),
    .ram_data_i     (ram_data_i)
  );

  // Attached RAM: combinational read, write on the clock edge.
  logic [DW-1:0] tb_mem [MS];
  bit            mem_inited;
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < MS; i++) tb_mem[i] <= 32'h1000_0000 + i;
      mem_inited <= 1'b1;
    end else if (ram_write_en_o) begin
      tb_mem[ram_address_o] <= ram_data_o;
    end
  end
  assign ram_data_i = tb_mem[ram_address_o];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the outputs must be this cycle, and what the registered ones must be next.
  bit            m_inited;
  bit            m_clear;
  int            m_idx;
  int            m_fav;
  int            m_last;
  logic [DW-1:0] m_mem [MS];
  logic [1:0]    m_rsp_v;
  logic [DW-1:0] m_rsp_d;
  bit            m_done;

  always @(negedge clk) begin : compare
    int            g;
    logic [1:0]    eg;
    logic          ewe;
    int            ea;
    logic [DW-1:0] ed;
    if (!m_inited) begin
      for (int i = 0; i < MS; i++) m_mem[i] = 32'h1000_0000 + i;
      m_inited = 1'b1;
    end
    if (!rst_n) begin
      m_clear = 0; m_idx = 0; m_fav = 0; m_last = 0;
      m_rsp_v = '0; m_rsp_d = '0; m_done = 0;
      check("rst_ready", req_ready_o, 0);
      check("rst_we", ram_write_en_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_rsp_valid", rsp_valid_o, 0);
      check("rst_done", done_o, 0);
    end else begin
      check("rsp_valid", rsp_valid_o, m_rsp_v);
      check("rsp_data", rsp_data_o, m_rsp_d);
      check("done", done_o, m_done);
      check("busy", busy_o, m_clear);
      m_rsp_v = '0; m_done = 0;
      eg = '0; ewe = 1'b0; ea = m_last; ed = '0;
      if (m_clear) begin
        ewe = 1'b1; ea = m_idx; ed = '0;
        m_mem[m_idx] = '0;
        m_idx++;
        if (m_idx == MS) begin
          m_clear = 0;
          m_done  = 1;
        end
      end else if (clear_i) begin
        m_clear = 1;
        m_idx   = 0;
      end else begin
        if (req_valid_i == 2'b11)      g = m_fav;
        else if (req_valid_i == 2'b01) g = 0;
        else if (req_valid_i == 2'b10) g = 1;
        else                           g = -1;
        if (g >= 0) begin
          eg    = 2'(1 << g);
          ewe   = req_write_i[g];
          ea    = int'(req_address_i[g*AW +: AW]);
          ed    = req_data_i[g*DW +: DW];
          m_fav = 1 - g;
          if (ewe) m_mem[ea] = ed;
          else begin
            m_rsp_v = eg;
            m_rsp_d = m_mem[ea];
          end
        end
      end
      m_last = ea;
      check("ready", req_ready_o, eg);
      check("we", ram_write_en_o, ewe);
      check("addr", ram_address_o, ea);
      if (ewe) check("wdata", ram_data_o, ed);
    end
  end

  task automatic drive_random(input int cycles, input bit allow_clear);
    logic [1:0] held;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      held = req_valid_i & ~req_ready_o;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (!held[k]) begin
          req_valid_i[k]            = ($urandom_range(0, 9) < 7);
          req_write_i[k]            = 1'($urandom_range(0, 1));
          req_address_i[k*AW +: AW] = AW'($urandom_range(0, MS-1));
          req_data_i[k*DW +: DW]    = $urandom;
        end
      end
      clear_i = allow_clear && ($urandom_range(0, 59) == 0);
    end
    clear_i = 1'b0;
  endtask

  task automatic idle(input int cycles);
    @(posedge clk); #1;
    req_valid_i = '0;
    clear_i     = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic run_clear(input int repulse_at, input int reset_at,
                           output int busy_n, output int done_n);
    @(posedge clk); #1;
    req_valid_i = '0;
    clear_i     = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    busy_n  = 0;
    done_n  = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == repulse_at) clear_i = 1'b1;
      if (i == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("reset_busy_now", busy_o, 0);
      end
      if (i == reset_at + 2) rst_n = 1'b1;
      @(negedge clk);
      busy_n += int'(busy_o);
      done_n += int'(done_o);
      @(posedge clk); #1;
      clear_i = 1'b0;
    end
  endtask

  int busy_n, done_n;

  initial begin
    req_valid_i   = 2'b11;
    req_write_i   = 2'b00;
    req_address_i = {4'd1, 4'd0};
    repeat (2) @(negedge clk);
    check("reset_no_grant", req_ready_o, 2'b00);
    check("reset_rsp_data", rsp_data_o, 0);
    check("reset_busy", busy_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_alternate", req_ready_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
    end

    rst_n = 1'b0;
    req_valid_i = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid_i   = 2'b01;
    req_write_i   = 2'b01;
    req_address_i = {4'd0, 4'd5};
    req_data_i    = {32'h0, 32'hDEADBEEF};
    @(negedge clk);
    check("write_grant", req_ready_o, 2'b01);
    @(posedge clk); #1;
    check("ram_holds_write", tb_mem[5], 32'hDEADBEEF);
    req_valid_i   = 2'b10;
    req_write_i   = 2'b00;
    req_address_i = {4'd5, 4'd0};
    @(negedge clk);
    check("read_grant", req_ready_o, 2'b10);
    @(posedge clk); #1;
    req_valid_i = '0;
    @(negedge clk);
    check("read_rsp_valid", rsp_valid_o, 2'b10);
    check("read_rsp_data", rsp_data_o, 32'hDEADBEEF);

    drive_random(400, 1'b1);
    idle(20);

    run_clear(-1, -1, busy_n, done_n);
    check("clear_busy_cycles", busy_n, 16);
    check("clear_done_pulses", done_n, 1);
    for (int a = 0; a < MS; a++) check("cleared_word", tb_mem[a], 0);
    for (int a = 0; a < MS; a += 5) begin
      req_valid_i   = 2'b01;
      req_write_i   = 2'b00;
      req_address_i = {4'd0, 4'(a)};
      @(posedge clk); #1;
      req_valid_i = '0;
      @(negedge clk);
      check("read_after_clear", rsp_data_o, 0);
      @(posedge clk); #1;
    end

    drive_random(150, 1'b0);
    idle(4);
    run_clear(5, -1, busy_n, done_n);
    check("reclear_busy_cycles", busy_n, 16);
    check("reclear_done_pulses", done_n, 1);

    drive_random(100, 1'b0);
    idle(4);
    run_clear(-1, 7, busy_n, done_n);
    check("abort_busy_cycles", busy_n, 7);
    check("abort_no_done", done_n, 0);
    req_valid_i   = 2'b11;
    req_write_i   = 2'b00;
    req_address_i = {4'd9, 4'd2};
    @(negedge clk);
    check("abort_first_contest", req_ready_o, 2'b01);
    @(posedge clk); #1;
    req_valid_i = '0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
